// File: rtl/synchronous_packet_fifo_if.sv
// rtl/synchronous_packet_fifo_if.sv - write/read bundle of the store-and-forward packet FIFO.
// master = ingress/forwarding side, slave = the FIFO itself.
interface synchronous_packet_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4096
);
  localparam int PTR_W = $clog2(DATA_DEPTH) + 1;

  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_last;
  logic                  write_abort;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_data_last;
  logic                  read_data_valid;
  logic                  full;
  logic                  empty;
  logic [PTR_W-1:0]      packet_count;
  logic                  dropped_packet;
  logic [15:0]           dropped_packet_count;

  modport master (
    output write_enable, write_data, write_last, write_abort, read_enable,
    input  read_data, read_data_last, read_data_valid, full, empty,
    input  packet_count, dropped_packet, dropped_packet_count
  );

  modport slave (
    input  write_enable, write_data, write_last, write_abort, read_enable,
    output read_data, read_data_last, read_data_valid, full, empty,
    output packet_count, dropped_packet, dropped_packet_count
  );
endinterface

// File: rtl/synchronous_packet_fifo.sv
// rtl/synchronous_packet_fifo.sv - store-and-forward packet FIFO, standard or FWFT read.
// Optional saturating drop counter: define SYNCHRONOUS_PACKET_FIFO_DROP_COUNTER_EN.
module synchronous_packet_fifo #(
  parameter int DATA_WIDTH              = 16,
  parameter int DATA_DEPTH              = 4096,
  parameter int FIRST_WORD_FALL_THROUGH = 0
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  synchronous_packet_fifo_if.slave  bus
);
  localparam int AW   = $clog2(DATA_DEPTH);
  localparam int PW   = AW + 1;
  localparam bit FWFT = (FIRST_WORD_FALL_THROUGH != 0);

  typedef enum logic {ST_ACCEPT, ST_DISCARD} wr_state_t;

  wr_state_t             r_state;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_commit_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_packet_count;
  logic                  r_dropped;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_last;
  logic                  r_read_valid;
  logic [DATA_WIDTH:0]   r_mem [DATA_DEPTH];

  logic                  w_full;
  logic                  w_mem_empty;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_commit;
  logic                  w_pop;
  logic                  w_pop_last;
  logic [DATA_WIDTH:0]   w_head;

  // full looks at the speculative write pointer so an oversized frame can never overrun unread data
  assign w_full      = (r_wr_ptr - r_rd_ptr) == PW'(DATA_DEPTH);
  assign w_mem_empty = (r_commit_ptr == r_rd_ptr);
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop       = !w_mem_empty && (FWFT ? (!r_read_valid || bus.read_enable) : bus.read_enable);
  assign w_pop_last  = w_pop && w_head[DATA_WIDTH];

  always_comb begin
    w_accept = 1'b0;
    w_drop   = 1'b0;
    w_commit = 1'b0;
    if (r_state == ST_ACCEPT) begin
      if (bus.write_abort || (bus.write_enable && w_full)) begin
        w_drop = 1'b1;
      end else if (bus.write_enable) begin
        w_accept = 1'b1;
        w_commit = bus.write_last;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_ACCEPT;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_dropped    <= 1'b0;
    end else begin
      r_dropped <= w_drop;
      case (r_state)
        ST_ACCEPT: begin
          if (w_drop) begin
            r_wr_ptr <= r_commit_ptr;
            if (!bus.write_last) r_state <= ST_DISCARD;
          end else if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_commit) r_commit_ptr <= r_wr_ptr + 1'b1;
          end
        end
        ST_DISCARD: begin
          if (bus.write_enable && bus.write_last) r_state <= ST_ACCEPT;
        end
        default: r_state <= ST_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_accept) r_mem[r_wr_ptr[AW-1:0]] <= {bus.write_last, bus.write_data};
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_packet_count <= '0;
    end else begin
      case ({w_commit, w_pop_last})
        2'b10:   r_packet_count <= r_packet_count + 1'b1;
        2'b01:   r_packet_count <= r_packet_count - 1'b1;
        default: r_packet_count <= r_packet_count;
      endcase
    end
  end

  // FWFT keeps the presented word until it is acknowledged; standard mode pulses valid per pop
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_ptr     <= '0;
      r_read_data  <= '0;
      r_read_last  <= 1'b0;
      r_read_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_read_data  <= w_head[DATA_WIDTH-1:0];
        r_read_last  <= w_head[DATA_WIDTH];
        r_read_valid <= 1'b1;
      end else if (!FWFT || bus.read_enable) begin
        r_read_valid <= 1'b0;
      end
    end
  end

`ifdef SYNCHRONOUS_PACKET_FIFO_DROP_COUNTER_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign bus.dropped_packet_count = r_drop_count;
`else
  assign bus.dropped_packet_count = '0;
`endif

  assign bus.read_data       = r_read_data;
  assign bus.read_data_last  = r_read_last;
  assign bus.read_data_valid = r_read_valid;
  assign bus.full            = w_full;
  assign bus.empty           = FWFT ? !r_read_valid : w_mem_empty;
  assign bus.packet_count    = r_packet_count;
  assign bus.dropped_packet  = r_dropped;
endmodule

// File: tb/tb_synchronous_packet_fifo.sv
// tb/tb_synchronous_packet_fifo.sv - standard and FWFT instances against a queue-level packet model.
// Honours SYNCHRONOUS_PACKET_FIFO_DROP_COUNTER_EN for the expected drop count.
module tb_synchronous_packet_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int PW    = 4;
  typedef logic [DW:0] word_t;

  logic clk = 1'b0;
  logic rst_n;
  logic we = 1'b0, wl = 1'b0, wa = 1'b0, re_s = 1'b0, re_f = 1'b0;
  logic [DW-1:0] wd = '0;

  always #5 clk = ~clk;

  synchronous_packet_fifo_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) bs ();
  synchronous_packet_fifo_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) bf ();

  assign bs.write_enable = we;  assign bf.write_enable = we;
  assign bs.write_data   = wd;  assign bf.write_data   = wd;
  assign bs.write_last   = wl;  assign bf.write_last   = wl;
  assign bs.write_abort  = wa;  assign bf.write_abort  = wa;
  assign bs.read_enable  = re_s;
  assign bf.read_enable  = re_f;

  synchronous_packet_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FIRST_WORD_FALL_THROUGH(0))
    dut_s (.i_clock(clk), .i_reset_n(rst_n), .bus(bs));
  synchronous_packet_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FIRST_WORD_FALL_THROUGH(1))
    dut_f (.i_clock(clk), .i_reset_n(rst_n), .bus(bf));

  // index 0 = standard instance, 1 = FWFT instance
  word_t mq [2][$];
  word_t pq [2][$];
  bit    disc [2];
  int    pc [2];
  bit    ov [2];
  word_t od [2];
  bit    drop [2];
  int    dcnt [2];
  int    checks = 0;
  int    errors = 0;
  int    rem = 3;
  int    exp_dc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete(); pq[i].delete();
      disc[i] = 0; pc[i] = 0; ov[i] = 0; od[i] = '0; drop[i] = 0; dcnt[i] = 0;
    end
  endtask

  task automatic step_model(input int i, input bit re);
    bit full_m, pop;
    word_t w;
    full_m = (mq[i].size() + pq[i].size()) == DEPTH;
    pop = (mq[i].size() > 0) && ((i == 0) ? re : (!ov[i] || re));
    if (pop) begin
      w = mq[i].pop_front();
      od[i] = w; ov[i] = 1;
      if (w[DW]) pc[i]--;
    end else if (i == 0 || re) begin
      ov[i] = 0;
    end
    drop[i] = 0;
    if (disc[i]) begin
      if (we && wl) disc[i] = 0;
    end else if (wa || (we && full_m)) begin
      pq[i].delete(); drop[i] = 1; disc[i] = !wl;
    end else if (we) begin
      pq[i].push_back({wl, wd});
      if (wl) begin
        for (int k = 0; k < pq[i].size(); k++) mq[i].push_back(pq[i][k]);
        pq[i].delete();
        pc[i]++;
      end
    end
    if (drop[i] && dcnt[i] < 65535) dcnt[i]++;
  endtask

  task automatic cmp_one(input int i, input logic [DW-1:0] rd, input logic rl, input logic rv,
                         input logic em, input logic fu, input logic [PW-1:0] pcnt,
                         input logic dp, input logic [15:0] dc);
    string p;
    p = (i == 0) ? "std" : "fwft";
    chk({p, "_valid"}, rv, ov[i]);
    if (ov[i]) begin
      chk({p, "_data"}, rd, od[i][DW-1:0]);
      chk({p, "_last"}, rl, od[i][DW]);
    end
    chk({p, "_empty"}, em, (i == 0) ? (mq[i].size() == 0) : !ov[i]);
    chk({p, "_full"}, fu, (mq[i].size() + pq[i].size()) == DEPTH);
    chk({p, "_pcount"}, pcnt, pc[i]);
    chk({p, "_drop"}, dp, drop[i]);
`ifdef SYNCHRONOUS_PACKET_FIFO_DROP_COUNTER_EN
    chk({p, "_dcount"}, dc, dcnt[i]);
`else
    chk({p, "_dcount"}, dc, 0);
`endif
  endtask

  task automatic compare_all();
    cmp_one(0, bs.read_data, bs.read_data_last, bs.read_data_valid, bs.empty, bs.full,
            bs.packet_count, bs.dropped_packet, bs.dropped_packet_count);
    cmp_one(1, bf.read_data, bf.read_data_last, bf.read_data_valid, bf.empty, bf.full,
            bf.packet_count, bf.dropped_packet, bf.dropped_packet_count);
  endtask

  task automatic cyc();
    @(posedge clk);
    step_model(0, re_s);
    step_model(1, re_f);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit last);
    we = 1; wd = d; wl = last; wa = 0;
    cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_data_std", bs.read_data, 0);
    chk("rst_data_fwft", bf.read_data, 0);
    chk("rst_empty_fwft", bf.empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    chk("reset_empty", bs.empty, 1);
    chk("reset_full", bs.full, 0);
    rst_n = 1'b1;

    wr(16'hA001, 0); wr(16'hA002, 0); wr(16'hA003, 1);
    chk("a_empty", bs.empty, 0);
    chk("a_pcount", bs.packet_count, 1);
    chk("a_fwft_notyet", bf.read_data_valid, 0);
    we = 0; wl = 0; re_s = 1;
    cyc();
    chk("a_fwft_valid", bf.read_data_valid, 1);
    chk("a_fwft_head", bf.read_data, 16'hA001);
    chk("a_rd1", bs.read_data, 16'hA001);
    chk("a_rd1_last", bs.read_data_last, 0);
    cyc();
    chk("a_rd2", bs.read_data, 16'hA002);
    cyc();
    chk("a_rd3", bs.read_data, 16'hA003);
    chk("a_rd3_last", bs.read_data_last, 1);
    chk("a_pcount0", bs.packet_count, 0);
    chk("a_empty1", bs.empty, 1);
    re_s = 0; re_f = 1;
    cyc(); cyc(); cyc();
    chk("a_fwft_drained", bf.read_data_valid, 0);
    re_f = 0;

    wr(16'hB000, 0); wr(16'hB001, 0);
    we = 0; wa = 1; wl = 1;
    cyc();
    chk("ab_pulse", bs.dropped_packet, 1);
    chk("ab_empty", bs.empty, 1);
    wa = 0; wl = 0;
    cyc();
    chk("ab_pulse_once", bs.dropped_packet, 0);
    wr(16'hB00B, 1);
    we = 0; wl = 0; re_s = 1; re_f = 1;
    cyc();
    chk("b_data", bs.read_data, 16'hB00B);
    chk("b_last", bs.read_data_last, 1);
    cyc();
    chk("b_only", bs.read_data_valid, 0);
    re_s = 0; re_f = 0;

    for (int k = 0; k < 10; k++) begin
      wr(16'hC000 + 16'(k), k == 9);
      if (k == 6) chk("ov_notfull", bs.full, 0);
      if (k == 7) begin
        chk("ov_full_std", bs.full, 1);
        chk("ov_full_fwft", bf.full, 1);
      end
      if (k == 8) chk("ov_drop", bs.dropped_packet, 1);
      if (k == 9) chk("ov_drop_once", bs.dropped_packet, 0);
    end
    we = 0; wl = 0;
    cyc();
    chk("ov_empty", bs.empty, 1);
    chk("ov_pcount", bs.packet_count, 0);
    wr(16'hD000, 0); wr(16'hD001, 1);
    we = 0; wl = 0; re_s = 1;
    cyc();
    chk("d_rd0", bs.read_data, 16'hD000);
    cyc();
    chk("d_rd1", bs.read_data, 16'hD001);
    chk("d_rd1_last", bs.read_data_last, 1);
    re_s = 0; re_f = 1;
    cyc(); cyc();
    re_f = 0;

    for (int k = 0; k < 4; k++) wr(16'hE000 + 16'(k), k == 3);
    chk("e_fwft_notyet", bf.read_data_valid, 0);
    we = 0; wl = 0;
    cyc();
    chk("e_fwft_rise", bf.read_data_valid, 1);
    chk("e_fwft_head", bf.read_data, 16'hE000);
    re_f = 1; re_s = 1;
    for (int k = 1; k < 4; k++) begin
      cyc();
      chk("e_fwft_stream_valid", bf.read_data_valid, 1);
      chk("e_fwft_stream_data", bf.read_data, 16'hE000 + 16'(k));
    end
    cyc();
    chk("e_fwft_fall", bf.read_data_valid, 0);
    re_f = 0; re_s = 0;

    wr(16'hF000, 1); wr(16'hF001, 0);
    we = 1; wd = 16'hF002; wl = 1; re_s = 1;
    cyc();
    chk("sim_pcount", bs.packet_count, 1);
    we = 0; wl = 0;
    cyc(); cyc(); cyc();
    chk("idle_read_valid", bs.read_data_valid, 0);
    chk("idle_read_pcount", bs.packet_count, 0);
    re_s = 0; re_f = 1;
    cyc(); cyc(); cyc(); cyc();
    re_f = 0;

    for (int k = 0; k < 3; k++) begin
      wa = 1; wl = 1;
      cyc();
      wa = 0; wl = 0;
      cyc();
    end
`ifdef SYNCHRONOUS_PACKET_FIFO_DROP_COUNTER_EN
    exp_dc = 5;
`else
    exp_dc = 0;
`endif
    chk("drop_count_std", bs.dropped_packet_count, exp_dc);
    chk("drop_count_fwft", bf.dropped_packet_count, exp_dc);

    wr(16'h6000, 0); wr(16'h6001, 0);
    we = 0; wl = 0;
    do_reset();
    chk("mid_rst_pcount", bs.packet_count, 0);
    chk("mid_rst_dcount", bs.dropped_packet_count, 0);
    wr(16'h7000, 1);
    we = 0; wl = 0; re_s = 1; re_f = 1;
    cyc(); cyc();

    for (int n = 0; n < 4000; n++) begin
      int rp;
      rp = ((n / 500) % 2 == 1) ? 20 : 70;
      if (n == 2100) begin
        we = 0; wl = 0; wa = 0;
        do_reset();
      end
      wa = ($urandom_range(0, 39) == 0);
      we = ($urandom_range(0, 99) < 80);
      if (we) begin
        wd = 16'($urandom);
        rem--;
        wl = (rem == 0);
        if (rem == 0) rem = $urandom_range(1, 11);
      end else begin
        wl = 1'($urandom_range(0, 1));
      end
      re_s = ($urandom_range(0, 99) < rp);
      re_f = ($urandom_range(0, 99) < rp);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
